// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants and fetch entry type
package mips_pkg;

  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] PC_INC = 32'(INST_BYTES);

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch stage bus: imem port, redirect port, decode handshake
interface ifetch_unit_if;
  import mips_pkg::*;

  logic [31:0]       imem_adr;
  logic [INST_W-1:0] imem_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc4;

  modport master (
    output imem_adr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_pc4
  );

  modport slave (
    input  imem_adr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_pc4
  );

endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - synchronous prefetch FIFO with flush and occupancy count
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC register, push/redirect control and prefetch queue
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  ifetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = bus.out_valid & bus.out_ready;
  // A full queue can still accept when the head leaves this same cycle.
  assign push      = !bus.redirect_valid & (!full | pop);
  assign push_data = '{pc: fetch_pc, inst: bus.imem_data};

  always_ff @(posedge clk) begin
    if (rst)
      fetch_pc <= RESET_PC;
    else if (bus.redirect_valid)
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
    else if (push)
      fetch_pc <= fetch_pc + PC_INC;
  end

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_adr  = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.out_pc4   = head.pc + PC_INC;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ifetch_unit_if ifa ();
  ifetch_unit_if ifb ();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] adr);
    logic [31:0] prog [9];
    prog[0] = 32'h0000_5020;
    prog[1] = 32'h2401_0014;
    prog[2] = 32'h1020_0004;
    prog[3] = 32'h0141_5020;
    prog[4] = 32'h2021_FFFF;
    prog[5] = 32'h0800_0002;
    prog[6] = 32'h0000_0000;
    prog[7] = 32'hAC0A_00C8;
    prog[8] = 32'h0800_0008;
    if (adr[15:6] == 10'd0 && adr[5:2] < 4'd9)
      return prog[adr[5:2]];
    return {16'hBEEF, adr[15:0]};
  endfunction

  assign ifa.imem_data = mem_word(ifa.imem_adr);
  assign ifb.imem_data = mem_word(ifb.imem_adr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, ifa.out_valid}, 32'd1);
    check({tag, "_pc"},    ifa.out_pc,   pc);
    check({tag, "_inst"},  ifa.out_inst, inst);
    check({tag, "_pc4"},   ifa.out_pc4,  pc + 32'd4);
  endtask

  initial begin
    rst                = 1'b1;
    ifa.out_ready      = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = 32'd0;
    ifb.out_ready      = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = 32'd0;

    // Reset state
    step(); step();
    check("rst_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("rst_adr",   ifa.imem_adr, 32'd0);
    check("rst_adr_b", ifb.imem_adr, 32'hFFFF_FFFC);
    rst = 1'b0;
    #1;
    check("rel_valid", {31'd0, ifa.out_valid}, 32'd0);

    // Streaming from reset, plus wrap on the second instance
    step();
    check_head("s0", 32'd0, 32'h0000_5020);
    check("wrap_pc0",  ifb.out_pc,   32'hFFFF_FFFC);
    check("wrap_pc4",  ifb.out_pc4,  32'd0);
    check("wrap_inst", ifb.out_inst, 32'hBEEF_FFFC);
    step();
    check_head("s1", 32'd4, 32'h2401_0014);
    check("wrap_pc1",  ifb.out_pc,   32'd0);
    check("wrap_inst1", ifb.out_inst, 32'h0000_5020);
    step();
    check_head("s2", 32'd8, 32'h1020_0004);

    // Backpressure straight out of reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head("bp_hold", 32'd0, 32'h0000_5020);
      check("bp_adr", ifa.imem_adr, (i == 0) ? 32'd4 : 32'd8);
    end
    ifa.out_ready = 1'b1;
    #1;
    check_head("bp_r0", 32'd0, 32'h0000_5020);
    step();
    check_head("bp_r1", 32'd4, 32'h2401_0014);
    step();
    check_head("bp_r2", 32'd8, 32'h1020_0004);
    step();
    check_head("bp_r3", 32'd12, 32'h0141_5020);

    // Fill, then redirect to 0x1C with a coinciding pop
    ifa.out_ready = 1'b0;
    step();
    step();
    check("full_adr", ifa.imem_adr, 32'd20);
    check("full_pc",  ifa.out_pc,   32'd12);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_001C;
    ifa.out_ready      = 1'b1;
    step();
    ifa.redirect_valid = 1'b0;
    check("redir_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("redir_adr",   ifa.imem_adr, 32'h0000_001C);
    step();
    check_head("redir_t", 32'h0000_001C, 32'hAC0A_00C8);
    step();
    check_head("redir_n", 32'h0000_0020, 32'h0800_0008);

    // Misaligned redirect target
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0009;
    step();
    ifa.redirect_valid = 1'b0;
    check("mis_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("mis_adr",   ifa.imem_adr, 32'd8);
    step();
    check_head("mis_t", 32'd8, 32'h1020_0004);

    // Reset beats a pending redirect on a full queue
    ifa.out_ready = 1'b0;
    step();
    step();
    check("pre_rst_adr", ifa.imem_adr, 32'd16);
    rst                = 1'b1;
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0040;
    step();
    check("rr_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("rr_adr",   ifa.imem_adr, 32'd0);
    rst                = 1'b0;
    ifa.redirect_valid = 1'b0;
    ifa.out_ready      = 1'b1;
    step();
    check_head("rr_first", 32'd0, 32'h0000_5020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage for the MIPS core. It owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction with its PC into a small prefetch queue. Decode drains the queue through a valid/ready handshake. A single redirect port (taken branch or jump from execute) flushes the queue and restarts fetch at a new target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch queue entries; power of two, ≥2.

- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- imem_adr  out  32  byte address to instruction memory; equals fetch_pc.
- imem_data  in  32  instruction word; combinational from imem_adr, same cycle.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  address of the head instruction.
- out_pc4  out  32  out_pc + 4, mod 2^32.

## Operation
- State: fetch_pc (32 b), queue of DEPTH entries {pc, inst}, rd_ptr, wr_ptr, count (0..DEPTH).
- Outputs are combinational from the head entry. out_valid = (count != 0).
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). A push writes {fetch_pc, imem_data} and sets fetch_pc ← fetch_pc + 4. Addition wraps mod 2^32; there is no overflow detection.
- Full queue with a pop in the same cycle: push is allowed and count is unchanged.
- Full queue without a pop: no push. fetch_pc holds, and imem_adr stays stable for the whole stall.
- redirect_valid = 1 has priority over everything else:
  - count ← 0 and pointers reset;
  - fetch_pc ← {redirect_pc[31:2], 2'b00};
  - no push that cycle.
- A pop coinciding with a redirect counts as accepted by decode, but the flush still discards every entry.
- Reset: fetch_pc = RESET_PC, count = 0, rd_ptr = wr_ptr = 0, out_valid = 0. out_inst, out_pc and out_pc4 are don't-care while out_valid = 0.
- rst asserted mid-stall or mid-redirect: reset wins and all in-flight entries are dropped.
- Misaligned or out-of-range addresses are not checked. The memory's own [15:0] indexing applies.

## Timing
- Fetch latency: fetch_pc = A at cycle n → entry for A is visible on out_* at cycle n+1, provided it was pushed.
- After reset release, the first out_valid appears one cycle later. Steady state with out_ready = 1 delivers 1 instruction per cycle.
- Redirect at cycle n:
  - out_valid = 0 at n+1;
  - imem_adr = target at n+1;
  - target instruction valid at n+2.
- Backpressure: when out_ready = 0, the head and out_valid are held stable until accepted (standard valid/ready; no valid drop without a pop or redirect).
- Queue fills in DEPTH cycles of backpressure. The push resumes in the same cycle as the first pop.

## Structure
- Shared package mips_pkg holds: INST_W = 32, INST_BYTES = 4, the PC_INC constant, and the typedef for the fetch entry {pc, inst}.
- Sub-module ifetch_queue: synchronous FIFO parameterised by DEPTH, with push/pop/flush and a count output.
- ifetch_unit contains the PC register, the push/redirect logic and the FIFO instance.

## Test plan
- Reset release with out_ready = 1 against the standard 9-instruction program → out_inst sequence 0x0000_5020, 0x2401_0014, 0x1020_0004, ... with out_pc 0, 4, 8, ...; out_valid first high 1 cycle after rst drops.
- Hold out_ready = 0 for 5 cycles → count saturates at 2, imem_adr holds at 8, and the head stays 0x0000_5020/pc 0. Release → pc 0, 4, 8 delivered back-to-back with no gap.
- redirect_valid with redirect_pc = 0x1C while the queue is full → out_valid = 0 next cycle, then out_pc = 0x1C and out_inst = 0xAC0A_00C8 (sw R10,200(R0)). No stale entries appear.
- redirect_pc = 0x0000_0009 → fetch restarts at 0x8 (low bits cleared).
- RESET_PC = 32'hFFFF_FFFC → first out_pc = 0xFFFF_FFFC with out_pc4 = 0, and the next out_pc = 0 (wrap).
- rst asserted while the queue is full and a redirect is pending → next cycle out_valid = 0 and imem_adr = RESET_PC.
